// File: rtl/tlb_search_arbiter.sv
// Arbitrates instruction- and data-side lookups onto a single TLB search port.
// Define TLB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data has fixed priority.
module tlb_search_arbiter #(
    parameter int VPN2_W = 19,
    parameter int PFN_W  = 20,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              i_req_valid,
    input  logic [VPN2_W-1:0] i_req_vpn2,
    input  logic              i_req_odd,
    input  logic              i_flush,

    input  logic              d_req_valid,
    input  logic [VPN2_W-1:0] d_req_vpn2,
    input  logic              d_req_odd,

    output logic              i_req_ready,
    output logic              d_req_ready,
    output logic              i_resp_valid,
    output logic              d_resp_valid,

    output logic              resp_found,
    output logic [IDX_W-1:0]  resp_index,
    output logic [PFN_W-1:0]  resp_pfn,
    output logic [2:0]        resp_c,
    output logic              resp_d,
    output logic              resp_v,

    output logic [VPN2_W-1:0] s_vpn2,
    output logic              s_odd_page,
    input  logic              s_found,
    input  logic [IDX_W-1:0]  s_index,
    input  logic [PFN_W-1:0]  s_pfn,
    input  logic [2:0]        s_c,
    input  logic              s_d,
    input  logic              s_v,

    input  logic              tlb_write
);

    typedef enum logic [1:0] {IDLE, LOOK, RESP} state_t;

    state_t            state;
    logic              owner_d;
    logic              cancel;
    logic [VPN2_W-1:0] vpn2_q;
    logic              odd_q;
    logic              grant_open;
    logic              i_grant;
    logic              d_grant;

    assign grant_open = (state == IDLE || state == RESP) && !tlb_write;

`ifdef TLB_ARB_ROUND_ROBIN_EN
    logic last_d;

    // On a tie the side that was not granted last wins; a flushed I side never competes.
    assign i_req_ready = grant_open && !i_flush && (!d_req_valid || last_d);
    assign d_req_ready = grant_open && (!(i_req_valid && !i_flush) || !last_d);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_d <= 1'b1;
        end else if (i_grant || d_grant) begin
            last_d <= d_grant;
        end
    end
`else
    assign i_req_ready = grant_open && !i_flush && !d_req_valid;
    assign d_req_ready = grant_open;
`endif

    assign i_grant = i_req_valid && i_req_ready;
    assign d_grant = d_req_valid && d_req_ready;

    assign s_vpn2     = vpn2_q;
    assign s_odd_page = odd_q;

    // A flush arriving in the response cycle itself must still kill the I pulse.
    assign i_resp_valid = (state == RESP) && !owner_d && !cancel && !i_flush;
    assign d_resp_valid = (state == RESP) && owner_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            cancel     <= 1'b0;
            vpn2_q     <= '0;
            odd_q      <= 1'b0;
            resp_found <= 1'b0;
            resp_index <= '0;
            resp_pfn   <= '0;
            resp_c     <= '0;
            resp_d     <= 1'b0;
            resp_v     <= 1'b0;
        end else begin
            case (state)
                LOOK: begin
                    resp_found <= s_found;
                    resp_index <= s_index;
                    resp_pfn   <= s_pfn;
                    resp_c     <= s_c;
                    resp_d     <= s_d;
                    resp_v     <= s_v;
                    if (!owner_d && i_flush) begin
                        cancel <= 1'b1;
                    end
                    state <= RESP;
                end
                default: begin
                    if (i_grant || d_grant) begin
                        owner_d <= d_grant;
                        vpn2_q  <= d_grant ? d_req_vpn2 : i_req_vpn2;
                        odd_q   <= d_grant ? d_req_odd : i_req_odd;
                        cancel  <= 1'b0;
                        state   <= LOOK;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Self-checking bench for tlb_search_arbiter: directed scenarios plus a randomized run
// checked against a transaction-timing reference model.
module tb_tlb_search_arbiter;

    localparam int VPN2_W = 19;
    localparam int PFN_W  = 20;
    localparam int IDX_W  = 4;
`ifdef TLB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              i_req_valid, i_req_odd, i_flush;
    logic [VPN2_W-1:0] i_req_vpn2;
    logic              d_req_valid, d_req_odd;
    logic [VPN2_W-1:0] d_req_vpn2;
    logic              i_req_ready, d_req_ready, i_resp_valid, d_resp_valid;
    logic              resp_found, resp_d, resp_v;
    logic [IDX_W-1:0]  resp_index;
    logic [PFN_W-1:0]  resp_pfn;
    logic [2:0]        resp_c;
    logic [VPN2_W-1:0] s_vpn2;
    logic              s_odd_page, s_found, s_d, s_v;
    logic [IDX_W-1:0]  s_index;
    logic [PFN_W-1:0]  s_pfn;
    logic [2:0]        s_c;
    logic              tlb_write;

    logic              ovr_en = 1'b0;
    logic              ovr_found = 1'b0;
    logic [PFN_W-1:0]  ovr_pfn = '0;

    int total = 0;
    int bad = 0;

    tlb_search_arbiter #(.VPN2_W(VPN2_W), .PFN_W(PFN_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .resetn(resetn),
        .i_req_valid(i_req_valid), .i_req_vpn2(i_req_vpn2), .i_req_odd(i_req_odd), .i_flush(i_flush),
        .d_req_valid(d_req_valid), .d_req_vpn2(d_req_vpn2), .d_req_odd(d_req_odd),
        .i_req_ready(i_req_ready), .d_req_ready(d_req_ready),
        .i_resp_valid(i_resp_valid), .d_resp_valid(d_resp_valid),
        .resp_found(resp_found), .resp_index(resp_index), .resp_pfn(resp_pfn),
        .resp_c(resp_c), .resp_d(resp_d), .resp_v(resp_v),
        .s_vpn2(s_vpn2), .s_odd_page(s_odd_page),
        .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v),
        .tlb_write(tlb_write)
    );

    always #5 clk = ~clk;

    // Behavioural TLB contents: a fixed hash of the searched page, optionally overridden.
    function automatic logic [PFN_W-1:0] tlb_pfn(input logic [VPN2_W-1:0] v, input logic o);
        return {v[18:3] ^ 16'hA5C3, v[2:0] ^ 3'b101, o};
    endfunction

    function automatic logic tlb_found(input logic [VPN2_W-1:0] v);
        return v[0] ^ v[5];
    endfunction

    always_comb begin
        s_found = ovr_en ? ovr_found : tlb_found(s_vpn2);
        s_pfn   = ovr_en ? ovr_pfn : tlb_pfn(s_vpn2, s_odd_page);
        s_index = s_vpn2[3:0] ^ s_vpn2[7:4];
        s_c     = s_vpn2[10:8];
        s_d     = s_vpn2[11];
        s_v     = s_vpn2[12] ^ s_odd_page;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req_valid = 1'b0; i_req_vpn2 = '0; i_req_odd = 1'b0; i_flush = 1'b0;
        d_req_valid = 1'b0; d_req_vpn2 = '0; d_req_odd = 1'b0; tlb_write = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 resetn = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({i_resp_valid, d_resp_valid} !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_resp_valid got=%b want=00", {i_resp_valid, d_resp_valid});
        end
        total++;
        if (resp_pfn !== '0 || resp_found !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_resp got pfn=%h found=%b want 0/0", resp_pfn, resp_found);
        end
        total++;
        if (s_vpn2 !== '0 || s_odd_page !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_svpn got=%h/%b want=0/0", s_vpn2, s_odd_page);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if ({i_req_ready, d_req_ready} !== 2'b11) begin
            bad++; $display("[TB] FAIL ready_after_reset got=%b want=11", {i_req_ready, d_req_ready});
        end
        tick();
        tlb_write = 1'b1;
        @(negedge clk);
        total++;
        if ({i_req_ready, d_req_ready} !== 2'b00) begin
            bad++; $display("[TB] FAIL ready_tlb_write got=%b want=00", {i_req_ready, d_req_ready});
        end
        tick();
        tlb_write = 1'b0;
        i_flush = 1'b1;
        @(negedge clk);
        total++;
        if ({i_req_ready, d_req_ready} !== 2'b01) begin
            bad++; $display("[TB] FAIL ready_flush got=%b want=01", {i_req_ready, d_req_ready});
        end
        tick();
        i_flush = 1'b0;
    endtask

    task automatic test_i_only();
        do_reset();
        ovr_en = 1'b1; ovr_found = 1'b1; ovr_pfn = 20'h0ABCD;
        i_req_valid = 1'b1; i_req_vpn2 = 19'h12345; i_req_odd = 1'b1;
        @(negedge clk);
        total++;
        if (i_req_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL i_only_grant got=%b want=1", i_req_ready);
        end
        tick();
        i_req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (s_vpn2 !== 19'h12345 || s_odd_page !== 1'b1) begin
            bad++; $display("[TB] FAIL i_only_svpn got=%h/%b want=12345/1", s_vpn2, s_odd_page);
        end
        tick();
        @(negedge clk);
        total++;
        if ({i_resp_valid, d_resp_valid} !== 2'b10) begin
            bad++; $display("[TB] FAIL i_only_resp_valid got=%b want=10", {i_resp_valid, d_resp_valid});
        end
        total++;
        if (resp_pfn !== 20'h0ABCD || resp_found !== 1'b1) begin
            bad++; $display("[TB] FAIL i_only_pfn got=%h/%b want=0abcd/1", resp_pfn, resp_found);
        end
        tick();
        @(negedge clk);
        total++;
        if (i_resp_valid !== 1'b0 || resp_pfn !== 20'h0ABCD) begin
            bad++; $display("[TB] FAIL i_only_one_pulse got=%b/%h want=0/0abcd", i_resp_valid, resp_pfn);
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic              first_d;
        logic [VPN2_W-1:0] fv, sv;
        do_reset();
        first_d = !RR;
        fv = first_d ? 19'h00222 : 19'h00111;
        sv = first_d ? 19'h00111 : 19'h00222;
        i_req_valid = 1'b1; i_req_vpn2 = 19'h00111; i_req_odd = 1'b0;
        d_req_valid = 1'b1; d_req_vpn2 = 19'h00222; d_req_odd = 1'b0;
        @(negedge clk);
        total++;
        if ({i_req_valid && i_req_ready, d_req_valid && d_req_ready} !== {!first_d, first_d}) begin
            bad++; $display("[TB] FAIL sim_first_grant got=%b want=%b",
                {i_req_valid && i_req_ready, d_req_valid && d_req_ready}, {!first_d, first_d});
        end
        tick();
        if (first_d) d_req_valid = 1'b0; else i_req_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({i_req_ready, d_req_ready} !== 2'b00) begin
            bad++; $display("[TB] FAIL sim_look_ready got=%b want=00", {i_req_ready, d_req_ready});
        end
        tick();
        @(negedge clk);
        total++;
        if ({i_resp_valid, d_resp_valid} !== {!first_d, first_d} || resp_pfn !== tlb_pfn(fv, 1'b0)) begin
            bad++; $display("[TB] FAIL sim_first_resp got=%b/%h want=%b/%h",
                {i_resp_valid, d_resp_valid}, resp_pfn, {!first_d, first_d}, tlb_pfn(fv, 1'b0));
        end
        total++;
        if ({i_req_valid && i_req_ready, d_req_valid && d_req_ready} !== {first_d, !first_d}) begin
            bad++; $display("[TB] FAIL sim_second_grant got=%b want=%b",
                {i_req_valid && i_req_ready, d_req_valid && d_req_ready}, {first_d, !first_d});
        end
        tick();
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if ({i_resp_valid, d_resp_valid} !== {first_d, !first_d} || resp_pfn !== tlb_pfn(sv, 1'b0)) begin
            bad++; $display("[TB] FAIL sim_second_resp got=%b/%h want=%b/%h",
                {i_resp_valid, d_resp_valid}, resp_pfn, {first_d, !first_d}, tlb_pfn(sv, 1'b0));
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        i_req_valid = 1'b1; i_req_vpn2 = 19'h00042;
        tick();
        i_req_valid = 1'b0; i_flush = 1'b1;
        @(negedge clk);
        total++;
        if (i_req_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_look_ready got=%b want=0", i_req_ready);
        end
        tick();
        i_flush = 1'b0;
        @(negedge clk);
        total++;
        if ({i_resp_valid, d_resp_valid} !== 2'b00) begin
            bad++; $display("[TB] FAIL flush_in_look got=%b want=00", {i_resp_valid, d_resp_valid});
        end
        tick();
        i_req_valid = 1'b1; i_req_vpn2 = 19'h00043;
        tick();
        i_req_valid = 1'b0;
        tick();
        i_flush = 1'b1;
        @(negedge clk);
        total++;
        if ({i_resp_valid, d_resp_valid} !== 2'b00) begin
            bad++; $display("[TB] FAIL flush_in_resp got=%b want=00", {i_resp_valid, d_resp_valid});
        end
        tick();
        i_flush = 1'b0;
        d_req_valid = 1'b1; d_req_vpn2 = 19'h00044;
        tick();
        d_req_valid = 1'b0; i_flush = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (d_resp_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL flush_data_owned got=%b want=1", d_resp_valid);
        end
        tick();
        i_flush = 1'b0;
    endtask

    task automatic test_tlb_write();
        do_reset();
        d_req_valid = 1'b1; d_req_vpn2 = 19'h00777; d_req_odd = 1'b1; tlb_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (d_req_ready !== 1'b0) begin
                bad++; $display("[TB] FAIL tlbw_block_%0d got=%b want=0", k, d_req_ready);
            end
            tick();
        end
        tlb_write = 1'b0;
        @(negedge clk);
        total++;
        if (d_req_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL tlbw_release got=%b want=1", d_req_ready);
        end
        tick();
        d_req_valid = 1'b0; tlb_write = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (d_resp_valid !== 1'b1 || resp_pfn !== tlb_pfn(19'h00777, 1'b1)) begin
            bad++; $display("[TB] FAIL tlbw_no_abort got=%b/%h want=1/%h", d_resp_valid, resp_pfn,
                tlb_pfn(19'h00777, 1'b1));
        end
        tick();
        tlb_write = 1'b0;
    endtask

    task automatic test_reset_mid_look();
        do_reset();
        ovr_en = 1'b1; ovr_found = 1'b1; ovr_pfn = 20'h05555;
        i_req_valid = 1'b1; i_req_vpn2 = 19'h00999;
        tick();
        i_req_valid = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            total++;
            if ({i_resp_valid, d_resp_valid} !== 2'b00 || resp_pfn !== '0) begin
                bad++; $display("[TB] FAIL reset_mid_look_%0d got=%b/%h want=00/0", k,
                    {i_resp_valid, d_resp_valid}, resp_pfn);
            end
        end
        ovr_en = 1'b0;
        tick();
    endtask

    task automatic test_d_not_found();
        do_reset();
        ovr_en = 1'b1; ovr_found = 1'b0; ovr_pfn = 20'h33333;
        d_req_valid = 1'b1; d_req_vpn2 = 19'h01234;
        tick();
        d_req_valid = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if (d_resp_valid !== 1'b1 || resp_found !== 1'b0 || resp_pfn !== 20'h33333) begin
            bad++; $display("[TB] FAIL d_miss got=%b/%b/%h want=1/0/33333", d_resp_valid, resp_found, resp_pfn);
        end
        ovr_found = 1'b1; ovr_pfn = 20'h11111;
        repeat (2) tick();
        @(negedge clk);
        total++;
        if (resp_found !== 1'b0 || resp_pfn !== 20'h33333 || d_resp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL d_miss_hold got=%b/%h/%b want=0/33333/0", resp_found, resp_pfn, d_resp_valid);
        end
        ovr_en = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic              iv, dv, io, dodd, ig, dg, in_look, in_resp, open, fl, tw;
        logic [VPN2_W-1:0] iva, dva, m_vpn, exp_svpn;
        logic              m_odd, exp_sodd, owner_d_m, m_cancel, m_last_d, busy, exp_ir, exp_dr, exp_found;
        logic [PFN_W-1:0]  exp_pfn;
        int                grant_cycle;
        do_reset();
        iv = 0; dv = 0; iva = '0; dva = '0; io = 0; dodd = 0;
        busy = 0; grant_cycle = 0; owner_d_m = 0; m_cancel = 0; m_last_d = 1;
        m_vpn = '0; m_odd = 0; exp_svpn = '0; exp_sodd = 0; exp_pfn = '0; exp_found = 0;
        for (int c = 0; c < 600; c++) begin
            if (!iv && $urandom_range(0, 2) == 0) begin iv = 1; iva = VPN2_W'($urandom); io = 1'($urandom); end
            if (!dv && $urandom_range(0, 2) == 0) begin dv = 1; dva = VPN2_W'($urandom); dodd = 1'($urandom); end
            fl = ($urandom_range(0, 7) == 0);
            tw = ($urandom_range(0, 7) == 0);
            i_req_valid = iv; i_req_vpn2 = iva; i_req_odd = io; i_flush = fl;
            d_req_valid = dv; d_req_vpn2 = dva; d_req_odd = dodd; tlb_write = tw;
            // One lookup in flight: grant at cycle g, search at g+1, answer at g+2.
            in_look = busy && (c == grant_cycle + 1);
            in_resp = busy && (c == grant_cycle + 2);
            if (in_look && !owner_d_m && fl) m_cancel = 1;
            open = !in_look && !tw;
            ig = iv && open && !fl;
            dg = dv && open;
            if (ig && dg) begin
                if (RR && m_last_d) dg = 0; else ig = 0;
            end
            exp_ir = in_resp && !owner_d_m && !m_cancel && !fl;
            exp_dr = in_resp && owner_d_m;
            @(negedge clk);
            total++;
            if ({i_req_valid && i_req_ready, d_req_valid && d_req_ready} !== {ig, dg}) begin
                bad++; $display("[TB] FAIL rnd_grant c=%0d got=%b want=%b", c,
                    {i_req_valid && i_req_ready, d_req_valid && d_req_ready}, {ig, dg});
            end
            total++;
            if ({i_resp_valid, d_resp_valid} !== {exp_ir, exp_dr}) begin
                bad++; $display("[TB] FAIL rnd_resp_valid c=%0d got=%b want=%b", c,
                    {i_resp_valid, d_resp_valid}, {exp_ir, exp_dr});
            end
            total++;
            if (resp_pfn !== exp_pfn || resp_found !== exp_found) begin
                bad++; $display("[TB] FAIL rnd_resp_data c=%0d got=%h/%b want=%h/%b", c,
                    resp_pfn, resp_found, exp_pfn, exp_found);
            end
            total++;
            if (s_vpn2 !== exp_svpn || s_odd_page !== exp_sodd) begin
                bad++; $display("[TB] FAIL rnd_search c=%0d got=%h/%b want=%h/%b", c,
                    s_vpn2, s_odd_page, exp_svpn, exp_sodd);
            end
            if (in_look) begin
                exp_pfn = tlb_pfn(m_vpn, m_odd);
                exp_found = tlb_found(m_vpn);
            end
            if (in_resp) busy = 0;
            if (ig || dg) begin
                busy = 1; grant_cycle = c; owner_d_m = dg; m_cancel = 0; m_last_d = dg;
                m_vpn = dg ? dva : iva;
                m_odd = dg ? dodd : io;
                exp_svpn = m_vpn; exp_sodd = m_odd;
                if (ig) iv = 0;
                if (dg) dv = 0;
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_i_only();
        test_simultaneous();
        test_flush();
        test_tlb_write();
        test_reset_mid_look();
        test_d_not_found();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlb_search_arbiter.md
TLB_SEARCH_ARBITER -- requirements
Module: tlb_search_arbiter

Interface
REQ-001 The block SHALL have parameter VPN2_W, default 19, meaning virtual page-pair number width.
REQ-002 The block SHALL have parameter PFN_W, default 20, meaning physical frame number width.
REQ-003 The block SHALL have parameter IDX_W, default 4, meaning TLB entry index width.
REQ-004 The block SHALL have ports `clk` (in, 1, sole clock) and `resetn` (in, 1, asynchronous active-low reset).
REQ-005 The block SHALL have instruction-side inputs `i_req_valid` (1), `i_req_vpn2` (VPN2_W), `i_req_odd` (1) and `i_flush` (1, cancels the instruction lookup).
REQ-006 The block SHALL have data-side inputs `d_req_valid` (1), `d_req_vpn2` (VPN2_W) and `d_req_odd` (1).
REQ-007 The block SHALL have outputs `i_req_ready` and `d_req_ready` (1 each, grant-accept).
REQ-008 The block SHALL have outputs `i_resp_valid` and `d_resp_valid` (1 each, one-cycle response pulse).
REQ-009 The block SHALL have shared response outputs `resp_found` (1), `resp_index` (IDX_W), `resp_pfn` (PFN_W), `resp_c` (3), `resp_d` (1), `resp_v` (1).
REQ-010 The block SHALL have TLB search-port outputs `s_vpn2` (VPN2_W) and `s_odd_page` (1).
REQ-011 The block SHALL have TLB search-port inputs `s_found`, `s_index`, `s_pfn`, `s_c`, `s_d`, `s_v` (combinational TLB result, same widths as resp_*).
REQ-012 The block SHALL have input `tlb_write` (1, TLBWI/TLBWR in progress; blocks new grants).

Function
REQ-013 The FSM SHALL have states IDLE, LOOK and RESP.
REQ-014 `x_req_ready` SHALL be 1 only in IDLE or RESP while `tlb_write`=0; `i_req_ready` SHALL additionally be 0 while `i_flush`=1.
REQ-015 A grant SHALL occur on `x_req_valid && x_req_ready`: owner, vpn2 and odd are registered, next state LOOK.
REQ-016 In LOOK, `s_vpn2`/`s_odd_page` SHALL be driven from the registered request and s_* SHALL be captured into resp_* at the clock edge; next state RESP.
REQ-017 In RESP, the owner's `x_resp_valid` SHALL be 1 for exactly one cycle; next state LOOK if a new grant occurs, else IDLE.
REQ-018 Latency SHALL be grant edge + 2 cycles to response; sustained throughput SHALL be one lookup per 2 cycles.
REQ-019 Requesters SHALL hold valid/vpn2/odd stable until ready; the block SHALL not buffer more than one request.
REQ-020 The non-owner's `x_resp_valid` SHALL remain 0; resp_* SHALL hold their last value outside RESP.
REQ-021 `i_flush` during LOOK with owner=I SHALL set a cancel flag that suppresses `i_resp_valid` in the following RESP.
REQ-022 `i_flush` in a RESP cycle with owner=I SHALL combinationally force `i_resp_valid` to 0.
REQ-023 Data-owned lookups SHALL be unaffected by `i_flush`.
REQ-024 `tlb_write` asserted mid-lookup SHALL not abort LOOK/RESP; it SHALL only block new grants.
REQ-025 Outside LOOK, `s_vpn2`/`s_odd_page` SHALL hold the last registered request.

Reset
REQ-026 On `resetn`=0, asynchronously: state IDLE, owner I, cancel 0, vpn2/odd registers 0, resp_* 0, both resp_valid 0, round-robin pointer "last=D".
REQ-027 Reset asserted mid-LOOK/RESP SHALL discard the lookup; no response pulse SHALL follow deassertion.
REQ-028 After reset, both req_ready SHALL be 1 when `tlb_write`=0 (and `i_flush`=0 for I).

Configuration
REQ-029 With TLB_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last; the pointer SHALL update on every grant.
REQ-030 Without TLB_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to D (fixed data priority), and no pointer register SHALL exist.

Verification
REQ-031 I-only request: vpn2=0x12345, odd=1 at t0; TLB returns found=1, pfn=0x0ABCD -> s_vpn2=0x12345 at t1, i_resp_valid=1 with pfn 0x0ABCD at t2, d_resp_valid=0.
REQ-032 Both valid out of reset: with macro -> I granted first, then D at t2, responses at t2 and t4; without macro -> D first, I next.
REQ-033 I granted t0, i_flush=1 at t1 -> no i_resp_valid at t2; i_req_ready=0 during t1.
REQ-034 tlb_write=1 for 3 cycles with d_req_valid=1 -> d_req_ready=0 for those cycles; grant on first cycle with tlb_write=0.
REQ-035 resetn pulsed low during LOOK -> state IDLE, resp_valid never pulses, resp_pfn=0.
REQ-036 D found=0 -> d_resp_valid=1 with resp_found=0; resp_* held until next RESP.
